vga_timing: RTL
===============

Name: vga_timing

Overview:
Free-running VGA raster timing generator for 800x600 @ 60 Hz with a 40 MHz pixel clock. It consumes the timing constants of the VGA package. It produces the pixel counters, sync and blanking flags that every downstream drawing stage (background, sprites, overlays) pipes along. It sits at the head of the video chain, directly after the clock/reset generation.

Parameters:
H_TOTAL, 1056, pixels per line including blanking (package H_MAX)
V_TOTAL, 628, lines per frame including blanking (package V_MAX)
H_BLANK_START, 800, first blanked pixel of a line
V_BLANK_START, 600, first blanked line of a frame
H_SYNC_START, 840, first hcount with hsync asserted
H_SYNC_STOP, 968, first hcount after hsync (exclusive)
V_SYNC_START, 601, first vcount with vsync asserted
V_SYNC_STOP, 605, first vcount after vsync (exclusive)
CNT_W, 11, counter width; must satisfy 2^CNT_W >= max(H_TOTAL, V_TOTAL)

Ports:
clk  input  1  40 MHz pixel clock
rst  input  1  asynchronous reset, active-high
en  input  1  pixel advance enable; counters step only when high (tie 1 for normal use)
hcount  output  CNT_W  current pixel column, 0..H_TOTAL-1
vcount  output  CNT_W  current line, 0..V_TOTAL-1
hsync  output  1  horizontal sync, active-high
vsync  output  1  vertical sync, active-high
hblnk  output  1  horizontal blanking
vblnk  output  1  vertical blanking
frame_start  output  1  one-cycle pulse when the raster wraps to (0,0)

Behaviour:
- All outputs are registered. No combinational path from any input to any output.
- Reset (rst high, asynchronous): hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, frame_start=0. Outputs hold these values until rst deasserts.
- First rising edge with rst low and en=1: hcount becomes 1.
- Counter stepping on each clk edge with en=1:
  - If hcount < H_TOTAL-1: hcount+1, vcount unchanged.
  - If hcount = H_TOTAL-1: hcount=0. Then vcount+1, or vcount=0 if vcount = V_TOTAL-1.
- en=0: all outputs hold their values. frame_start is forced to 0.
- Flag alignment: every flag is computed from the next-state counters and registered with them. Each flag therefore describes exactly the (hcount,vcount) shown in the same cycle, with zero skew:
  - hblnk = (hcount >= H_BLANK_START)
  - vblnk = (vcount >= V_BLANK_START)
  - hsync = (H_SYNC_START <= hcount < H_SYNC_STOP), i.e. high for hcount 840..967, 128 cycles.
  - vsync = (V_SYNC_START <= vcount < V_SYNC_STOP), i.e. high for lines 601..604, 4 lines.
- frame_start = 1 only in the cycle whose outputs show (0,0) reached by wrapping from (H_TOTAL-1, V_TOTAL-1) with en=1. It is not asserted out of reset.
- Period: line = 1056 enabled cycles; frame = 663168 enabled cycles. The raster never stalls except via en.
- Reset mid-frame: immediate return to the reset state regardless of counter position. No partial pulse survives.
- Counter arithmetic is unsigned CNT_W-bit. Values >= the TOTAL parameters are unreachable, with no overflow wrap path.

Test Plan:
- Reset then release with en=1 -> during reset all outputs 0; after 1 edge hcount=1, vcount=0; after 800 edges hcount=800, hblnk=1.
- Line timing -> hsync rises with hcount=840, falls with hcount=968. After hcount=1055 the next cycle shows hcount=0, vcount+1, hblnk=0.
- Frame timing -> vblnk=1 from vcount=600. vsync=1 exactly for vcount 601..604. After (1055,627): (0,0), frame_start=1 for one cycle, exactly 663168 cycles between consecutive pulses.
- en held 0 for 50 cycles at (839,10) -> all outputs frozen, frame_start=0. When en returns, the next cycle shows hcount=840, hsync=1.
- Assert rst asynchronously (between edges) at (500,300) -> outputs go to 0 without waiting for clk. Counting restarts from (0,0) with no frame_start pulse.
- Full-frame scoreboard over 2 frames -> at every cycle each flag matches its formula applied to the displayed (hcount,vcount).

Source files
------------

// File: rtl/vga_timing.sv
// vga_timing: free-running raster timing generator for 800x600 @ 60 Hz on a
// 40 MHz pixel clock. It produces the pixel/line counters plus sync, blanking
// and frame-start flags. The flags are all registered in the same cycle as the
// counters they describe, so downstream stages see them with no skew.
module vga_timing #(
  parameter int H_TOTAL       = 1056,
  parameter int V_TOTAL       = 628,
  parameter int H_BLANK_START = 800,
  parameter int V_BLANK_START = 600,
  parameter int H_SYNC_START  = 840,
  parameter int H_SYNC_STOP   = 968,
  parameter int V_SYNC_START  = 601,
  parameter int V_SYNC_STOP   = 605,
  parameter int CNT_W         = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             frame_start
);

  // Timing constants sized to the counter width so every compare is unsigned
  // and width-matched.
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_BS   = CNT_W'(H_BLANK_START);
  localparam logic [CNT_W-1:0] V_BS   = CNT_W'(V_BLANK_START);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_SYNC_START);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_SYNC_STOP);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_SYNC_START);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_SYNC_STOP);

  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             h_wrap;
  logic             v_wrap;
  logic             hsync_next;
  logic             vsync_next;
  logic             hblnk_next;
  logic             vblnk_next;
  logic             frame_wrap;

  // Next raster position. The counters only ever wrap on an exact terminal
  // match, so values at or above the totals are never produced.
  always_comb begin
    h_wrap = (hcount == H_LAST);
    v_wrap = (vcount == V_LAST);
    h_next = hcount + 1'b1;
    v_next = vcount;
    if (h_wrap) begin
      h_next = '0;
      v_next = v_wrap ? '0 : vcount + 1'b1;
    end
    frame_wrap = h_wrap && v_wrap;
  end

  // Flags decoded from the next position so they land with the counters.
  always_comb begin
    hblnk_next = (h_next >= H_BS);
    vblnk_next = (v_next >= V_BS);
    hsync_next = (h_next >= H_SS) && (h_next < H_SE);
    vsync_next = (v_next >= V_SS) && (v_next < V_SE);
  end

  // Output registers: advance on en, hold otherwise; frame_start is a
  // single-cycle pulse and never persists across a stalled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hcount      <= h_next;
      vcount      <= v_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      hblnk       <= hblnk_next;
      vblnk       <= vblnk_next;
      frame_start <= frame_wrap;
    end else begin
      frame_start <= 1'b0;
    end
  end

endmodule
